// File: rtl/mem_access_controller_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding,
// memory direction constants and the address wrap helper.
package mem_access_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ARM    = 3'd2,
        ST_STROBE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    // Depth need not be a power of two, so wrap explicitly instead of overflowing.
    function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
        return (addr + 1 == depth) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/mem_access_controller_burst_address_counter.sv
// Burst address/remaining-count tracker; loads a start address and length,
// steps with modulo-numWords wrap and flags the final word.
module burst_address_counter
    import mem_access_controller_pkg::*;
#(
    parameter  int numWords = 64,
    localparam int AW       = $clog2(numWords)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          load,
    input  logic [AW-1:0] start_address,
    input  logic [AW-1:0] length,
    input  logic          step,
    output logic [AW-1:0] address,
    output logic          last
);

    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] remaining_q, remaining_d;

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        if (load) begin
            addr_d      = start_address;
            remaining_d = length;
        end else if (step && remaining_q != '0) begin
            addr_d      = AW'(wrap_inc(32'(addr_q), unsigned'(numWords)));
            remaining_d = remaining_q - AW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    assign address = addr_q;
    assign last    = (remaining_q == '0);

endmodule

// File: rtl/mem_access_controller.sv
// Clocked burst initiator for the asynchronous level-triggered memory block:
// pins settle for a full cycle before a single-cycle enable strobe.
module mem_access_controller
    import mem_access_controller_pkg::*;
#(
    parameter  int wordSize = 4,
    parameter  int numWords = 64,
    localparam int AW       = $clog2(numWords)
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                reqValid,
    output logic                reqReady,
    input  logic                reqRead,
    input  logic [AW-1:0]       reqAddress,
    input  logic [AW-1:0]       reqLength,
    input  logic [wordSize-1:0] wrData,
    input  logic                wrValid,
    output logic                wrReady,
    output logic [wordSize-1:0] rdData,
    output logic                rdValid,
    input  logic                rdReady,
    output logic                done,
    output logic                memEnable,
    output logic                memReadWrite,
    output logic [AW-1:0]       memAddress,
    output logic [wordSize-1:0] memWrData,
    input  logic [wordSize-1:0] memRdData
);

    state_t              state_q, state_d;
    logic                started_q, started_d;
    logic                dir_q, dir_d;
    logic [wordSize-1:0] wr_data_q, wr_data_d;
    logic [wordSize-1:0] rd_data_q, rd_data_d;
    logic                done_q, done_d;

    logic accept;
    logic advance;
    logic last;

    assign accept  = reqValid && reqReady;
    // A word is finished after a write strobe or a consumed read response.
    assign advance = (state_q == ST_STROBE && dir_q == MEM_WRITE) ||
                     (state_q == ST_RESP && rdReady);

    burst_address_counter #(
        .numWords(numWords)
    ) u_counter (
        .clk          (clk),
        .resetN       (resetN),
        .load         (accept),
        .start_address(reqAddress),
        .length       (reqLength),
        .step         (advance && !last),
        .address      (memAddress),
        .last         (last)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  if (dir_q == MEM_READ || wrValid) state_d = ST_ARM;
            ST_ARM:    state_d = ST_STROBE;
            ST_STROBE: begin
                if (dir_q == MEM_READ) state_d = ST_RESP;
                else                   state_d = last ? ST_IDLE : ST_SETUP;
            end
            ST_RESP:   if (rdReady) state_d = last ? ST_IDLE : ST_SETUP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        reqReady  = started_q && (state_q == ST_IDLE);
        wrReady   = (state_q == ST_SETUP) && (dir_q == MEM_WRITE);
        rdValid   = (state_q == ST_RESP);
        memEnable = (state_q == ST_STROBE);
    end

    always_comb begin
        started_d = 1'b1;
        dir_d     = dir_q;
        wr_data_d = wr_data_q;
        rd_data_d = rd_data_q;
        done_d    = advance && last;
        if (accept) dir_d = reqRead;
        if (state_q == ST_SETUP && dir_q == MEM_WRITE && wrValid) wr_data_d = wrData;
        if (state_q == ST_STROBE && dir_q == MEM_READ) rd_data_d = memRdData;
    end

    // reqReady is held low until the first edge after reset release.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            started_q <= 1'b0;
            dir_q     <= MEM_READ;
            wr_data_q <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            started_q <= started_d;
            dir_q     <= dir_d;
            wr_data_q <= wr_data_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
        end
    end

    assign memReadWrite = dir_q;
    assign memWrData    = wr_data_q;
    assign rdData       = rd_data_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: behavioural async memory plus an array
// reference of expected contents, directed timing scenarios and random bursts.
module tb_mem_access_controller;
    import mem_access_controller_pkg::*;

    localparam int WS = 4;
    localparam int NW = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          resetN;
    logic          reqValid, reqReady, reqRead;
    logic [AW-1:0] reqAddress, reqLength;
    logic [WS-1:0] wrData;
    logic          wrValid, wrReady;
    logic [WS-1:0] rdData;
    logic          rdValid, rdReady, done;
    logic          memEnable, memReadWrite;
    logic [AW-1:0] memAddress;
    logic [WS-1:0] memWrData, memRdData;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WS-1:0] mem     [NW];
    logic [WS-1:0] ref_mem [NW];

    typedef struct packed {
        logic [AW-1:0] a;
        logic          rw;
        logic [WS-1:0] d;
    } strobe_t;
    strobe_t strobes[$];
    strobe_t mon_s;

    int            done_cnt = 0;
    int            pin_err  = 0;
    int            en_err   = 0;
    logic [AW-1:0] prev_a;
    logic          prev_rw;
    logic [WS-1:0] prev_d;
    logic          prev_en    = 1'b0;
    logic          prev_valid = 1'b0;

    mem_access_controller #(.wordSize(WS), .numWords(NW)) dut (
        .clk(clk), .resetN(resetN),
        .reqValid(reqValid), .reqReady(reqReady), .reqRead(reqRead),
        .reqAddress(reqAddress), .reqLength(reqLength),
        .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
        .rdData(rdData), .rdValid(rdValid), .rdReady(rdReady),
        .done(done),
        .memEnable(memEnable), .memReadWrite(memReadWrite),
        .memAddress(memAddress), .memWrData(memWrData), .memRdData(memRdData)
    );

    // Memory output is parked at zero while not enabled for reading.
    assign memRdData = (memEnable && memReadWrite) ? mem[memAddress] : '0;

    always #5 clk = ~clk;

    // Behavioural memory and pin monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!resetN) begin
            prev_valid = 1'b0;
            prev_en    = 1'b0;
        end else begin
            if (memEnable) begin
                mon_s.a  = memAddress;
                mon_s.rw = memReadWrite;
                mon_s.d  = memWrData;
                strobes.push_back(mon_s);
                if (memReadWrite == MEM_WRITE) mem[memAddress] = memWrData;
                if (prev_valid && {prev_a, prev_rw, prev_d} != {memAddress, memReadWrite, memWrData})
                    pin_err++;
                if (prev_en) en_err++;
            end
            if (done) done_cnt++;
            prev_a     = memAddress;
            prev_rw    = memReadWrite;
            prev_d     = memWrData;
            prev_en    = memEnable;
            prev_valid = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one burst to completion; returns read words and whether done was seen.
    task automatic run_burst(input logic rd, input logic [AW-1:0] a, input logic [AW-1:0] len,
                             input bit stall, input logic [WS-1:0] wd[$],
                             output logic [WS-1:0] got[$], output bit ok);
        int idx = 0;
        int cyc = 0;
        bit seen_done = 1'b0;
        got = {};
        while (!reqReady && cyc < 50) begin
            tick();
            cyc++;
        end
        reqValid   = 1'b1;
        reqRead    = rd;
        reqAddress = a;
        reqLength  = len;
        tick();
        reqValid = 1'b0;
        cyc = 0;
        while (!seen_done && cyc < 4000) begin
            wrValid = !rd && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
            wrData  = (idx < wd.size()) ? wd[idx] : '0;
            rdReady = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (wrReady && wrValid) idx++;
            if (rdValid && rdReady) got.push_back(rdData);
            tick();
            cyc++;
            if (done) seen_done = 1'b1;
        end
        wrValid = 1'b0;
        rdReady = 1'b0;
        ok = seen_done;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            reqValid   = 1'($urandom);
            reqRead    = 1'($urandom);
            reqAddress = AW'($urandom);
            reqLength  = AW'($urandom);
            wrData     = WS'($urandom);
            wrValid    = 1'($urandom);
            rdReady    = 1'($urandom);
            tick();
            n_checks++;
            if ({reqReady, wrReady, rdValid, done, memEnable, memReadWrite} !== 6'b000001) begin
                n_fail++;
                $display("FAIL reset_ctrl: got %b expected 000001", {reqReady, wrReady, rdValid, done, memEnable, memReadWrite});
            end
            n_checks++;
            if ({rdData, memAddress, memWrData} !== '0) begin
                n_fail++;
                $display("FAIL reset_data: got rdData=%0h addr=%0d wdata=%0h expected zeros", rdData, memAddress, memWrData);
            end
        end
        reqValid = 1'b0;
        wrValid  = 1'b0;
        rdReady  = 1'b0;
        resetN   = 1'b1;
        #1;
        n_checks++;
        if (reqReady !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_before_edge: reqReady got %b expected 0", reqReady);
        end
        tick();
        n_checks++;
        if (reqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_after_edge: reqReady got %b expected 1", reqReady);
        end
    endtask

    task automatic test_single_write();
        int d0 = done_cnt;
        strobes = {};
        reqValid = 1'b1; reqRead = MEM_WRITE; reqAddress = 6'd5; reqLength = '0;
        wrValid = 1'b1; wrData = 4'hA;
        tick();
        reqValid = 1'b0;
        n_checks++;
        if ({wrReady, memEnable, memReadWrite, memAddress} !== {1'b1, 1'b0, 1'b0, 6'd5}) begin
            n_fail++;
            $display("FAIL wr_setup: got wrReady=%b en=%b rw=%b addr=%0d expected 1 0 0 5", wrReady, memEnable, memReadWrite, memAddress);
        end
        tick();
        wrValid = 1'b0;
        n_checks++;
        if ({memEnable, memWrData} !== {1'b0, 4'hA}) begin
            n_fail++;
            $display("FAIL wr_arm: got en=%b wdata=%0h expected 0 a", memEnable, memWrData);
        end
        tick();
        n_checks++;
        if ({memEnable, memReadWrite, memAddress, memWrData, done} !== {1'b1, 1'b0, 6'd5, 4'hA, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_strobe: got en=%b rw=%b addr=%0d wdata=%0h done=%b expected 1 0 5 a 0", memEnable, memReadWrite, memAddress, memWrData, done);
        end
        tick();
        n_checks++;
        if ({done, memEnable, reqReady} !== 3'b101) begin
            n_fail++;
            $display("FAIL wr_done: got done=%b en=%b reqReady=%b expected 1 0 1", done, memEnable, reqReady);
        end
        tick();
        ref_mem[5] = 4'hA;
        n_checks++;
        if (done !== 1'b0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL wr_done_pulse: got done=%b pulses=%0d expected 0 1", done, done_cnt - d0);
        end
        n_checks++;
        if (mem[5] !== 4'hA || strobes.size() != 1) begin
            n_fail++;
            $display("FAIL wr_mem: got mem[5]=%0h strobes=%0d expected a 1", mem[5], strobes.size());
        end
    endtask

    task automatic test_single_read();
        reqValid = 1'b1; reqRead = MEM_READ; reqAddress = 6'd5; reqLength = '0;
        rdReady = 1'b0;
        tick();
        reqValid = 1'b0;
        n_checks++;
        if ({memEnable, memReadWrite, memAddress, rdValid} !== {1'b0, 1'b1, 6'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_setup: got en=%b rw=%b addr=%0d rdValid=%b expected 0 1 5 0", memEnable, memReadWrite, memAddress, rdValid);
        end
        tick();
        n_checks++;
        if (memEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_arm: memEnable got %b expected 0", memEnable);
        end
        tick();
        n_checks++;
        if ({memEnable, rdValid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rd_strobe: got en=%b rdValid=%b expected 1 0", memEnable, rdValid);
        end
        tick();
        rdReady = 1'b1;
        n_checks++;
        if ({rdValid, rdData, memEnable} !== {1'b1, ref_mem[5], 1'b0}) begin
            n_fail++;
            $display("FAIL rd_resp: got rdValid=%b data=%0h en=%b expected 1 %0h 0", rdValid, rdData, memEnable, ref_mem[5]);
        end
        tick();
        rdReady = 1'b0;
        n_checks++;
        if ({done, rdValid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rd_done: got done=%b rdValid=%b expected 1 0", done, rdValid);
        end
    endtask

    task automatic test_write_backpressure();
        logic [AW-1:0] a = AW'($urandom_range(0, NW - 1));
        logic [WS-1:0] d = WS'($urandom);
        reqValid = 1'b1; reqRead = MEM_WRITE; reqAddress = a; reqLength = '0;
        wrValid = 1'b0;
        tick();
        reqValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wrData = WS'($urandom);
            n_checks++;
            if ({memEnable, wrReady, memAddress} !== {1'b0, 1'b1, a}) begin
                n_fail++;
                $display("FAIL wbp_stall%0d: got en=%b wrReady=%b addr=%0d expected 0 1 %0d", i, memEnable, wrReady, memAddress, a);
            end
            tick();
        end
        wrValid = 1'b1;
        wrData  = d;
        tick();
        wrValid = 1'b0;
        n_checks++;
        if ({memEnable, memWrData, memAddress} !== {1'b0, d, a}) begin
            n_fail++;
            $display("FAIL wbp_arm: got en=%b wdata=%0h addr=%0d expected 0 %0h %0d", memEnable, memWrData, memAddress, d, a);
        end
        tick();
        n_checks++;
        if (memEnable !== 1'b1) begin
            n_fail++;
            $display("FAIL wbp_strobe: memEnable got %b expected 1", memEnable);
        end
        tick();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wbp_done: done got %b expected 1", done);
        end
        ref_mem[a] = d;
        n_checks++;
        if (mem[a] !== d) begin
            n_fail++;
            $display("FAIL wbp_mem: mem[%0d] got %0h expected %0h", a, mem[a], d);
        end
    endtask

    task automatic test_read_backpressure();
        logic [AW-1:0] a = AW'($urandom_range(0, NW - 1));
        int s0;
        strobes = {};
        reqValid = 1'b1; reqRead = MEM_READ; reqAddress = a; reqLength = '0;
        rdReady = 1'b0;
        tick();
        reqValid = 1'b0;
        tick();
        tick();
        tick();
        s0 = strobes.size();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({rdValid, rdData, memEnable} !== {1'b1, ref_mem[a], 1'b0}) begin
                n_fail++;
                $display("FAIL rbp_hold%0d: got rdValid=%b data=%0h en=%b expected 1 %0h 0", i, rdValid, rdData, memEnable, ref_mem[a]);
            end
            tick();
        end
        n_checks++;
        if (strobes.size() != s0 || s0 != 1) begin
            n_fail++;
            $display("FAIL rbp_strobes: got %0d strobes expected 1", strobes.size());
        end
        rdReady = 1'b1;
        tick();
        rdReady = 1'b0;
        n_checks++;
        if ({done, rdValid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rbp_done: got done=%b rdValid=%b expected 1 0", done, rdValid);
        end
    endtask

    task automatic test_wrapping_read();
        logic [WS-1:0] wd[$];
        logic [WS-1:0] got[$];
        logic [AW-1:0] exp_a[4];
        bit ok;
        int d0;
        wd = '{4'h1, 4'h2, 4'h3, 4'h4};
        exp_a = '{6'd62, 6'd63, 6'd0, 6'd1};
        run_burst(MEM_WRITE, 6'd62, 6'd3, 1'b1, wd, got, ok);
        for (int i = 0; i < 4; i++) ref_mem[exp_a[i]] = wd[i];
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wrap_preload_timeout: done got 0 expected 1");
        end
        tick();
        strobes = {};
        d0 = done_cnt;
        run_burst(MEM_READ, 6'd62, 6'd3, 1'b1, wd, got, ok);
        tick();
        n_checks++;
        if (!ok || done_cnt - d0 != 1 || strobes.size() != 4 || got.size() != 4) begin
            n_fail++;
            $display("FAIL wrap_shape: got ok=%b dones=%0d strobes=%0d words=%0d expected 1 1 4 4", ok, done_cnt - d0, strobes.size(), got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (strobes[i].a !== exp_a[i] || strobes[i].rw !== MEM_READ) begin
                    n_fail++;
                    $display("FAIL wrap_addr%0d: got %0d rw=%b expected %0d 1", i, strobes[i].a, strobes[i].rw, exp_a[i]);
                end
                n_checks++;
                if (got[i] !== WS'(i + 1)) begin
                    n_fail++;
                    $display("FAIL wrap_data%0d: got %0h expected %0h", i, got[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_random_bursts();
        for (int it = 0; it < 10; it++) begin
            logic          rd  = 1'($urandom);
            logic [AW-1:0] a   = AW'($urandom_range(0, NW - 1));
            logic [AW-1:0] len = (it == 4) ? 6'd63 : AW'($urandom_range(0, 9));
            logic [WS-1:0] wd[$];
            logic [WS-1:0] got[$];
            bit ok;
            int d0;
            int bad = 0;
            if (it == 4) rd = MEM_WRITE;
            for (int i = 0; i <= int'(len); i++) wd.push_back(WS'($urandom));
            strobes = {};
            d0 = done_cnt;
            pin_err = 0;
            en_err = 0;
            run_burst(rd, a, len, 1'b1, wd, got, ok);
            tick();
            n_checks++;
            if (!ok || done_cnt - d0 != 1 || strobes.size() != int'(len) + 1) begin
                n_fail++;
                $display("FAIL rnd%0d_shape: got ok=%b dones=%0d strobes=%0d expected 1 1 %0d", it, ok, done_cnt - d0, strobes.size(), int'(len) + 1);
                continue;
            end
            for (int i = 0; i <= int'(len); i++) begin
                int ea = (int'(a) + i) % NW;
                if (strobes[i].a !== AW'(ea) || strobes[i].rw !== rd) bad++;
                else if (rd == MEM_WRITE && strobes[i].d !== wd[i]) bad++;
                else if (rd == MEM_READ && (i >= got.size() || got[i] !== ref_mem[ea])) bad++;
                if (rd == MEM_WRITE) ref_mem[ea] = wd[i];
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rnd%0d_words: got %0d wrong words expected 0 (rd=%b a=%0d len=%0d)", it, bad, rd, a, len);
            end
            n_checks++;
            if (pin_err != 0 || en_err != 0) begin
                n_fail++;
                $display("FAIL rnd%0d_pins: got pin_err=%0d en_err=%0d expected 0 0", it, pin_err, en_err);
            end
        end
    endtask

    task automatic test_reset_during_strobe();
        logic [AW-1:0] a = AW'($urandom_range(0, NW - 1));
        logic [AW-1:0] ra = AW'((int'(a) + 20) % NW);
        logic [WS-1:0] wd[$];
        logic [WS-1:0] got[$];
        bit ok;
        int cyc = 0;
        int d0;
        reqValid = 1'b1; reqRead = MEM_WRITE; reqAddress = a; reqLength = 6'd3;
        wrValid = 1'b1; wrData = WS'($urandom);
        tick();
        reqValid = 1'b0;
        while (!memEnable && cyc < 20) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != 2) begin
            n_fail++;
            $display("FAIL rst_strobe_latency: got %0d cycles after SETUP expected 2", cyc);
        end
        d0 = done_cnt;
        resetN = 1'b0;
        #1;
        n_checks++;
        if ({memEnable, reqReady, wrReady} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_strobe_drop: got en=%b reqReady=%b wrReady=%b expected 0 0 0", memEnable, reqReady, wrReady);
        end
        wrValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({done, memEnable} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_hold%0d: got done=%b en=%b expected 0 0", i, done, memEnable);
            end
        end
        resetN = 1'b1;
        tick();
        n_checks++;
        if (reqReady !== 1'b1 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL rst_recover: got reqReady=%b extra dones=%0d expected 1 0", reqReady, done_cnt - d0);
        end
        run_burst(MEM_READ, ra, '0, 1'b0, wd, got, ok);
        n_checks++;
        if (!ok || got.size() != 1 || got[0] !== ref_mem[ra]) begin
            n_fail++;
            $display("FAIL rst_new_req: got ok=%b words=%0d data=%0h expected 1 1 %0h", ok, got.size(), (got.size() > 0) ? got[0] : 4'h0, ref_mem[ra]);
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            mem[i]     = WS'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_single_write();
        test_single_read();
        test_write_backpressure();
        test_read_backpressure();
        test_wrapping_read();
        test_random_bursts();
        test_reset_during_strobe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
